// File: rtl/descriptor_reader.sv
// Read side of the descriptor BRAM: fetches packed histogram words one at a time
// and streams their bins over a valid/ready interface, LSB bin first.
module descriptor_reader #(
    parameter int NUM_DESCRIPTORS = 64,
    parameter int NUM_BINS        = 8,
    parameter int BIN_WIDTH       = 2,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start,
    input  logic [$clog2(NUM_DESCRIPTORS+1)-1:0]   desc_count,
    output logic [$clog2(NUM_DESCRIPTORS)-1:0]     read_addr,
    input  logic [NUM_BINS*BIN_WIDTH-1:0]          bram_data_in,
    output logic                                   bin_valid,
    input  logic                                   bin_ready,
    output logic [BIN_WIDTH-1:0]                   bin_data,
    output logic [$clog2(NUM_BINS)-1:0]            bin_index,
    output logic [$clog2(NUM_DESCRIPTORS)-1:0]     desc_index,
    output logic                                   bin_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int W  = NUM_BINS * BIN_WIDTH;
    localparam int CW = $clog2(NUM_DESCRIPTORS + 1);
    localparam int AW = $clog2(NUM_DESCRIPTORS);
    localparam int IW = $clog2(NUM_BINS);
    localparam int LW = $clog2(BRAM_LATENCY + 2);

    localparam logic [CW-1:0] MAX_COUNT  = CW'(NUM_DESCRIPTORS);
    localparam logic [CW-1:0] ZERO_COUNT = CW'(1'b0);
    localparam logic [IW-1:0] LAST_BIN   = IW'(NUM_BINS - 1);
    localparam logic [LW-1:0] LAT_LAST   = LW'(BRAM_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   count_r;
    logic [LW-1:0]   lat_cnt_r;
    logic [W-1:0]    word_r;

    logic            transfer_s;
    logic            last_bin_s;
    logic            last_desc_s;
    logic            fetch_done_s;
    logic [IW-1:0]   next_bin_s;
    logic [CW-1:0]   start_count_s;

    function automatic logic [BIN_WIDTH-1:0] get_bin(input logic [W-1:0] word,
                                                     input logic [IW-1:0] idx);
        logic [W-1:0] shifted;
        shifted = word >> (idx * BIN_WIDTH);
        return shifted[BIN_WIDTH-1:0];
    endfunction

    // Handshake and position decodes shared by the FSM and the datapath.
    always_comb begin
        transfer_s   = bin_valid && bin_ready;
        last_bin_s   = (bin_index == LAST_BIN);
        last_desc_s  = (CW'(desc_index) == (count_r - CW'(1'b1)));
        fetch_done_s = (lat_cnt_r == LAT_LAST);
        next_bin_s   = bin_index + IW'(1'b1);
        if (desc_count > MAX_COUNT) begin
            start_count_s = MAX_COUNT;
        end else begin
            start_count_s = desc_count;
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (desc_count == ZERO_COUNT) begin
                        next_state_s = FINISH;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (fetch_done_s) begin
                    next_state_s = SEND;
                end else begin
                    next_state_s = FETCH;
                end
            end
            SEND: begin
                if (transfer_s && last_bin_s) begin
                    if (last_desc_s) begin
                        next_state_s = FINISH;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = SEND;
                end
            end
            FINISH:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Address sequencing, word capture and the registered stream outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_r    <= '0;
            lat_cnt_r  <= '0;
            word_r     <= '0;
            read_addr  <= '0;
            desc_index <= '0;
            bin_index  <= '0;
            bin_data   <= '0;
            bin_valid  <= 1'b0;
            bin_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (state_r == FINISH);
            case (state_r)
                IDLE: begin
                    if (start && (desc_count != ZERO_COUNT)) begin
                        count_r    <= start_count_s;
                        read_addr  <= '0;
                        desc_index <= '0;
                        lat_cnt_r  <= '0;
                    end
                end
                FETCH: begin
                    // The BRAM output for read_addr is valid in the final counted cycle.
                    if (fetch_done_s) begin
                        word_r    <= bram_data_in;
                        bin_data  <= bram_data_in[BIN_WIDTH-1:0];
                        bin_index <= '0;
                        bin_valid <= 1'b1;
                        bin_last  <= last_desc_s && (NUM_BINS == 1);
                        lat_cnt_r <= '0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LW'(1'b1);
                    end
                end
                SEND: begin
                    if (transfer_s) begin
                        if (last_bin_s) begin
                            bin_valid <= 1'b0;
                            bin_last  <= 1'b0;
                            lat_cnt_r <= '0;
                            if (!last_desc_s) begin
                                desc_index <= desc_index + AW'(1'b1);
                                read_addr  <= read_addr + AW'(1'b1);
                            end
                        end else begin
                            bin_index <= next_bin_s;
                            bin_data  <= get_bin(word_r, next_bin_s);
                            bin_last  <= (next_bin_s == LAST_BIN) && last_desc_s;
                        end
                    end
                end
                FINISH: begin
                    bin_valid <= 1'b0;
                end
                default: begin
                    bin_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
